dma_response_router: RTL and testbench

- Return-path companion to the channel round-robin arbiter. Records, in grant order, which channel won each arbitrated transaction.
- Steers the shared response stream (read data or write response) back to the owning channel, one transaction at a time, retiring the entry on the last beat.
- Sits between the AXI master response interface and the per-channel engines. Its grantReady output gates the arbiter's grantEn.

---
 rtl/dma_response_router.sv | 121 ++++++++++++
 tb/tb_dma_response_router.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_response_router.sv
// dma_response_router: remembers which channel won each arbitrated transaction
// and steers the shared response stream back to that channel in grant order.
module dma_response_router #(
  parameter int NO_OF_CHANNELS  = 4,
  parameter int MAX_OUTSTANDING = 8,
  parameter int DATA_WIDTH      = 64
) (
  input  logic                               clock,
  input  logic                               resetn,
  input  logic [NO_OF_CHANNELS-1:0]          grant,
  input  logic                               grantEn,
  output logic                               grantReady,
  input  logic                               rspValid,
  input  logic                               rspLast,
  input  logic [DATA_WIDTH-1:0]              rspData,
  output logic                               rspReady,
  output logic [NO_OF_CHANNELS-1:0]          chRspValid,
  output logic [NO_OF_CHANNELS-1:0]          chRspLast,
  output logic [DATA_WIDTH-1:0]              chRspData,
  input  logic [NO_OF_CHANNELS-1:0]          chRspReady,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               errGrant,
  output logic                               errStray
);

  localparam int ID_W   = (NO_OF_CHANNELS > 1) ? $clog2(NO_OF_CHANNELS) : 1;
  localparam int ADDR_W = $clog2(MAX_OUTSTANDING);
  localparam int PTR_W  = ADDR_W + 1;

  // Ownership FIFO storage and pointers; the extra pointer MSB separates full from empty
  logic [ID_W-1:0]  fifo_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             err_grant_q, err_grant_d;
  logic             err_stray_q, err_stray_d;

  logic [ID_W-1:0]  grant_idx;
  logic             grant_onehot;
  logic [ID_W-1:0]  head;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [PTR_W-1:0] count;

  // Live entries fall out of the pointer difference; wrap-around is plain binary overflow
  assign count       = wr_ptr_q - rd_ptr_q;
  assign outstanding = count;
  assign full        = (count == PTR_W'(MAX_OUTSTANDING));
  assign empty       = (count == '0);
  assign grantReady  = ~full;
  assign errGrant    = err_grant_q;
  assign errStray    = err_stray_q;
  assign chRspData   = rspData;
  assign head        = fifo_q[rd_ptr_q[ADDR_W-1:0]];

  // Convert the one-hot grant into a channel index and flag malformed grant vectors
  always_comb begin
    grant_idx    = '0;
    grant_onehot = (grant != '0) &&
                   ((grant & (grant - NO_OF_CHANNELS'(1))) == '0);
    for (int i = 0; i < NO_OF_CHANNELS; i++) begin
      if (grant[i]) begin
        grant_idx = ID_W'(i);
      end
    end
  end

  // Steer the shared beat to the head owner; with nothing recorded the stream stalls
  always_comb begin
    chRspValid = '0;
    chRspLast  = '0;
    rspReady   = 1'b0;
    if (!empty) begin
      for (int i = 0; i < NO_OF_CHANNELS; i++) begin
        if (head == ID_W'(i)) begin
          chRspValid[i] = rspValid;
          chRspLast[i]  = rspLast;
          rspReady      = chRspReady[i];
        end
      end
    end
  end

  // Next-state for pointers and error flags; full blocks a push even if a pop happens this cycle
  always_comb begin
    push        = grantEn & ~full & grant_onehot;
    pop         = rspValid & rspReady & rspLast;
    wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    err_grant_d = grantEn & (~grant_onehot | full);
    err_stray_d = err_stray_q | (rspValid & empty);
  end

  // Register pointers and error flags; reset discards every recorded owner at once
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      err_grant_q <= 1'b0;
      err_stray_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      err_grant_q <= err_grant_d;
      err_stray_q <= err_stray_d;
    end
  end

  // Write the winning channel index into the slot addressed by the write pointer
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        fifo_q[i] <= '0;
      end
    end else if (push) begin
      fifo_q[wr_ptr_q[ADDR_W-1:0]] <= grant_idx;
    end
  end

endmodule

// File: tb/tb_dma_response_router.sv
// tb_dma_response_router: scoreboard bench; expected owners are queued at grant
// time and compared against the routed channel when each beat is presented.
module tb_dma_response_router;

  localparam int N  = 4;
  localparam int M  = 8;
  localparam int DW = 64;

  logic          clock = 1'b0;
  logic          resetn;
  logic [N-1:0]  grant;
  logic          grantEn;
  logic          grantReady;
  logic          rspValid;
  logic          rspLast;
  logic [DW-1:0] rspData;
  logic          rspReady;
  logic [N-1:0]  chRspValid;
  logic [N-1:0]  chRspLast;
  logic [DW-1:0] chRspData;
  logic [N-1:0]  chRspReady;
  logic [3:0]    outstanding;
  logic          errGrant;
  logic          errStray;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];

  // Free-running clock, 10 time units per period
  always #5 clock = ~clock;

  dma_response_router #(
    .NO_OF_CHANNELS (N),
    .MAX_OUTSTANDING(M),
    .DATA_WIDTH     (DW)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .grant      (grant),
    .grantEn    (grantEn),
    .grantReady (grantReady),
    .rspValid   (rspValid),
    .rspLast    (rspLast),
    .rspData    (rspData),
    .rspReady   (rspReady),
    .chRspValid (chRspValid),
    .chRspLast  (chRspLast),
    .chRspData  (chRspData),
    .chRspReady (chRspReady),
    .outstanding(outstanding),
    .errGrant   (errGrant),
    .errStray   (errStray)
  );

  // Watchdog so the run always ends even if a scenario stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout reached");
    $fatal(1, "[TB] watchdog");
  end

  // Present a grant for one cycle; called at posedge+1, returns at posedge+1
  task automatic push_grant(input logic [N-1:0] g);
    grant   = g;
    grantEn = 1'b1;
    @(posedge clock); #1;
    grantEn = 1'b0;
    grant   = '0;
  endtask

  // Present one response beat for one cycle and capture the routed outputs mid-cycle
  task automatic beat(input logic last, input logic [N-1:0] rdy,
                      output logic [N-1:0] vld, output logic [N-1:0] lst,
                      output logic rr, output logic data_ok);
    logic [DW-1:0] d;
    d          = {$urandom, $urandom};
    rspValid   = 1'b1;
    rspLast    = last;
    rspData    = d;
    chRspReady = rdy;
    @(negedge clock);
    vld     = chRspValid;
    lst     = chRspLast;
    rr      = rspReady;
    data_ok = (chRspData === d);
    @(posedge clock); #1;
    rspValid   = 1'b0;
    rspLast    = 1'b0;
    chRspReady = '1;
  endtask

  task automatic test_reset();
    checks++;
    if (grantReady !== 1'b1 || rspReady !== 1'b0 || chRspValid !== '0 ||
        chRspLast !== '0 || outstanding !== 4'd0 || errGrant !== 1'b0 ||
        errStray !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_state got gr=%b rr=%b vld=%b last=%b out=%0d eg=%b es=%b expected 1 0 0000 0000 0 0 0",
               grantReady, rspReady, chRspValid, chRspLast, outstanding, errGrant, errStray);
    end
  endtask

  task automatic test_basic_routing();
    logic [N-1:0] v, l, exp_v;
    logic r, dok;
    push_grant(4'b0100); exp_q.push_back(2);
    push_grant(4'b0001); exp_q.push_back(0);
    checks++;
    if (outstanding !== 4'd2) begin
      failures++;
      $display("[TB] FAIL basic_count2 got %0d expected 2", outstanding);
    end
    for (int b = 0; b < 3; b++) begin
      exp_v = N'(1) << exp_q[0];
      beat(b == 2, '1, v, l, r, dok);
      checks++;
      if (v !== exp_v || l !== ((b == 2) ? exp_v : 4'b0000) || r !== 1'b1 || dok !== 1'b1) begin
        failures++;
        $display("[TB] FAIL basic_beat%0d got vld=%b last=%b rdy=%b data_ok=%b expected vld=%b last=%b rdy=1 data_ok=1",
                 b, v, l, r, dok, exp_v, (b == 2) ? exp_v : 4'b0000);
      end
    end
    exp_q.pop_front();
    checks++;
    if (outstanding !== 4'd1) begin
      failures++;
      $display("[TB] FAIL basic_count1 got %0d expected 1", outstanding);
    end
    exp_v = N'(1) << exp_q[0];
    beat(1'b1, '1, v, l, r, dok);
    checks++;
    if (v !== exp_v || l !== exp_v || r !== 1'b1) begin
      failures++;
      $display("[TB] FAIL basic_single got vld=%b last=%b rdy=%b expected vld=%b last=%b rdy=1",
               v, l, r, exp_v, exp_v);
    end
    exp_q.pop_front();
    checks++;
    if (outstanding !== 4'd0) begin
      failures++;
      $display("[TB] FAIL basic_count0 got %0d expected 0", outstanding);
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] v, l, exp_v;
    logic r, dok;
    push_grant(4'b0010); exp_q.push_back(1);
    exp_v = N'(1) << exp_q[0];
    for (int c = 0; c < 5; c++) begin
      beat(1'b1, 4'b1101, v, l, r, dok);
      checks++;
      if (v !== exp_v || r !== 1'b0 || outstanding !== 4'd1) begin
        failures++;
        $display("[TB] FAIL backpressure_stall%0d got vld=%b rdy=%b out=%0d expected vld=%b rdy=0 out=1",
                 c, v, r, outstanding, exp_v);
      end
    end
    beat(1'b1, '1, v, l, r, dok);
    checks++;
    if (v !== exp_v || l !== exp_v || r !== 1'b1 || outstanding !== 4'd0) begin
      failures++;
      $display("[TB] FAIL backpressure_release got vld=%b last=%b rdy=%b out=%0d expected vld=%b last=%b rdy=1 out=0",
               v, l, r, outstanding, exp_v, exp_v);
    end
    exp_q.pop_front();
  endtask

  task automatic test_full();
    logic [N-1:0] v, l, exp_v;
    logic r, dok;
    for (int i = 0; i < M; i++) begin
      push_grant(N'(1) << (i % N));
      exp_q.push_back(i % N);
    end
    checks++;
    if (outstanding !== 4'd8 || grantReady !== 1'b0) begin
      failures++;
      $display("[TB] FAIL full_state got out=%0d gr=%b expected out=8 gr=0", outstanding, grantReady);
    end
    push_grant(4'b0001);
    checks++;
    if (errGrant !== 1'b1 || outstanding !== 4'd8) begin
      failures++;
      $display("[TB] FAIL full_reject got eg=%b out=%0d expected eg=1 out=8", errGrant, outstanding);
    end
    @(posedge clock); #1;
    checks++;
    if (errGrant !== 1'b0) begin
      failures++;
      $display("[TB] FAIL full_errpulse got eg=%b expected eg=0", errGrant);
    end
    exp_v = N'(1) << exp_q[0];
    beat(1'b1, '1, v, l, r, dok);
    exp_q.pop_front();
    checks++;
    if (v !== exp_v || r !== 1'b1 || grantReady !== 1'b1 || outstanding !== 4'd7) begin
      failures++;
      $display("[TB] FAIL full_pop got vld=%b rdy=%b gr=%b out=%0d expected vld=%b rdy=1 gr=1 out=7",
               v, r, grantReady, outstanding, exp_v);
    end
    while (exp_q.size() > 0) begin
      exp_v = N'(1) << exp_q[0];
      beat(1'b1, '1, v, l, r, dok);
      checks++;
      if (v !== exp_v || l !== exp_v || r !== 1'b1) begin
        failures++;
        $display("[TB] FAIL full_drain got vld=%b last=%b rdy=%b expected vld=%b last=%b rdy=1",
                 v, l, r, exp_v, exp_v);
      end
      exp_q.pop_front();
    end
  endtask

  task automatic test_wrap_around();
    logic [N-1:0] v, l, exp_v;
    logic r, dok;
    int nc;
    push_grant(4'b0001); exp_q.push_back(0);
    push_grant(4'b0010); exp_q.push_back(1);
    for (int k = 0; k < 20; k++) begin
      nc         = (k + 2) % N;
      exp_v      = N'(1) << exp_q[0];
      grant      = N'(1) << nc;
      grantEn    = 1'b1;
      rspValid   = 1'b1;
      rspLast    = 1'b1;
      rspData    = {$urandom, $urandom};
      chRspReady = '1;
      @(negedge clock);
      checks++;
      if (chRspValid !== exp_v || chRspLast !== exp_v || rspReady !== 1'b1 ||
          outstanding !== 4'd2 || grantReady !== 1'b1) begin
        failures++;
        $display("[TB] FAIL wrap_cycle%0d got vld=%b last=%b rdy=%b out=%0d gr=%b expected vld=%b last=%b rdy=1 out=2 gr=1",
                 k, chRspValid, chRspLast, rspReady, outstanding, grantReady, exp_v, exp_v);
      end
      @(posedge clock); #1;
      exp_q.pop_front();
      exp_q.push_back(nc);
    end
    grantEn  = 1'b0;
    grant    = '0;
    rspValid = 1'b0;
    rspLast  = 1'b0;
    checks++;
    if (outstanding !== 4'd2) begin
      failures++;
      $display("[TB] FAIL wrap_count got %0d expected 2", outstanding);
    end
    while (exp_q.size() > 0) begin
      exp_v = N'(1) << exp_q[0];
      beat(1'b1, '1, v, l, r, dok);
      checks++;
      if (v !== exp_v || l !== exp_v || r !== 1'b1) begin
        failures++;
        $display("[TB] FAIL wrap_drain got vld=%b last=%b rdy=%b expected vld=%b last=%b rdy=1",
                 v, l, r, exp_v, exp_v);
      end
      exp_q.pop_front();
    end
  endtask

  task automatic test_errors();
    push_grant(4'b0110);
    checks++;
    if (errGrant !== 1'b1 || outstanding !== 4'd0) begin
      failures++;
      $display("[TB] FAIL err_multihot got eg=%b out=%0d expected eg=1 out=0", errGrant, outstanding);
    end
    push_grant(4'b0000);
    checks++;
    if (errGrant !== 1'b1 || outstanding !== 4'd0) begin
      failures++;
      $display("[TB] FAIL err_zero got eg=%b out=%0d expected eg=1 out=0", errGrant, outstanding);
    end
    @(posedge clock); #1;
    checks++;
    if (errGrant !== 1'b0 || errStray !== 1'b0) begin
      failures++;
      $display("[TB] FAIL err_quiet got eg=%b es=%b expected eg=0 es=0", errGrant, errStray);
    end
    rspValid = 1'b1;
    rspLast  = 1'b1;
    @(negedge clock);
    checks++;
    if (rspReady !== 1'b0 || chRspValid !== '0) begin
      failures++;
      $display("[TB] FAIL stray_stall got rdy=%b vld=%b expected rdy=0 vld=0000", rspReady, chRspValid);
    end
    @(posedge clock); #1;
    rspValid = 1'b0;
    rspLast  = 1'b0;
    checks++;
    if (errStray !== 1'b1) begin
      failures++;
      $display("[TB] FAIL stray_set got es=%b expected es=1", errStray);
    end
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (errStray !== 1'b1) begin
      failures++;
      $display("[TB] FAIL stray_sticky got es=%b expected es=1", errStray);
    end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] v, l, exp_v;
    logic r, dok;
    push_grant(4'b1000); exp_q.push_back(3);
    exp_v = N'(1) << exp_q[0];
    beat(1'b0, '1, v, l, r, dok);
    checks++;
    if (v !== exp_v || l !== 4'b0000 || r !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midreset_beat1 got vld=%b last=%b rdy=%b expected vld=%b last=0000 rdy=1",
               v, l, r, exp_v);
    end
    rspValid = 1'b1;
    rspLast  = 1'b0;
    @(negedge clock);
    checks++;
    if (chRspValid !== exp_v) begin
      failures++;
      $display("[TB] FAIL midreset_beat2 got vld=%b expected vld=%b", chRspValid, exp_v);
    end
    #1 resetn = 1'b0;
    #1;
    checks++;
    if (chRspValid !== '0 || rspReady !== 1'b0 || outstanding !== 4'd0 || grantReady !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midreset_async got vld=%b rdy=%b out=%0d gr=%b expected vld=0000 rdy=0 out=0 gr=1",
               chRspValid, rspReady, outstanding, grantReady);
    end
    rspValid = 1'b0;
    exp_q.delete();
    @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (errStray !== 1'b0 || outstanding !== 4'd0 || grantReady !== 1'b1 || chRspValid !== '0) begin
      failures++;
      $display("[TB] FAIL midreset_after got es=%b out=%0d gr=%b vld=%b expected es=0 out=0 gr=1 vld=0000",
               errStray, outstanding, grantReady, chRspValid);
    end
  endtask

  // Scenario sequence
  initial begin
    resetn     = 1'b0;
    grant      = '0;
    grantEn    = 1'b0;
    rspValid   = 1'b0;
    rspLast    = 1'b0;
    rspData    = '0;
    chRspReady = '1;
    #2;
    test_reset();
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock); #1;
    test_basic_routing();
    test_backpressure();
    test_full();
    test_wrap_around();
    test_errors();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
